// File: rtl/fxp_seq_pkg.sv
// Shared types and encodings for the fixed-point element sequencer.
package fxp_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_e;

    localparam int unsigned vsaddu_vv  = 1;
    localparam int unsigned vsaddu_vx  = 2;
    localparam int unsigned vsaddu_vi  = 3;
    localparam int unsigned vsadd_vv   = 4;
    localparam int unsigned vsadd_vx   = 5;
    localparam int unsigned vsadd_vi   = 6;
    localparam int unsigned vssubu_vv  = 7;
    localparam int unsigned vssubu_vx  = 8;
    localparam int unsigned vssub_vv   = 9;
    localparam int unsigned vssub_vx   = 10;
    localparam int unsigned vaadd_vv   = 11;
    localparam int unsigned vaadd_vx   = 12;
    localparam int unsigned vaaddu_vv  = 13;
    localparam int unsigned vaaddu_vx  = 14;
    localparam int unsigned vasub_vv   = 15;
    localparam int unsigned vasub_vx   = 16;
    localparam int unsigned vasubu_vv  = 17;
    localparam int unsigned vasubu_vx  = 18;
    localparam int unsigned vsmul_vv   = 19;
    localparam int unsigned vsmul_vx   = 20;
    localparam int unsigned vssrl_vv   = 21;
    localparam int unsigned vssrl_vx   = 22;
    localparam int unsigned vssrl_vi   = 23;
    localparam int unsigned vssra_vv   = 24;
    localparam int unsigned vssra_vx   = 25;
    localparam int unsigned vssra_vi   = 26;
    localparam int unsigned vnclipu_wv = 27;
    localparam int unsigned vnclipu_wx = 28;
    localparam int unsigned vnclipu_wi = 29;
    localparam int unsigned vnclip_wv  = 30;
    localparam int unsigned vnclip_wx  = 31;
    localparam int unsigned vnclip_wi  = 32;

    localparam int unsigned OP_MIN = vsaddu_vv;
    localparam int unsigned OP_MAX = vnclip_wi;

    localparam int unsigned SEW8  = 0;
    localparam int unsigned SEW16 = 1;
    localparam int unsigned SEW32 = 2;
    localparam int unsigned SEW64 = 3;

    function automatic logic fxp_illegal(input int unsigned op, input int unsigned vsew);
        return (op < OP_MIN) || (op > OP_MAX) || (vsew > SEW64);
    endfunction

endpackage

// File: rtl/fixed_point_sequencer_if.sv
// Issue-side and datapath-side signal bundle of the fixed-point sequencer.
interface fixed_point_sequencer_if #(
    parameter int ELEM_W = 8,
    parameter int OP_W   = 6
);
    import fxp_seq_pkg::*;

    logic              issue_valid;
    logic              issue_ready;
    logic [OP_W-1:0]   issue_op;
    logic [ELEM_W-1:0] issue_vl;
    logic [2:0]        issue_vsew;
    logic [1:0]        issue_vxrm;
    logic              issue_vm;
    logic              mask_bit;
    logic              dp_valid;
    logic              dp_ready;
    logic [OP_W-1:0]   dp_op;
    logic [2:0]        dp_vsew;
    logic [1:0]        dp_vxrm;
    logic [ELEM_W-1:0] dp_elem_idx;
    logic              dp_resp_valid;
    logic              dp_resp_sat;

    modport master (
        input  issue_valid, issue_op, issue_vl, issue_vsew, issue_vxrm, issue_vm,
               mask_bit, dp_ready, dp_resp_valid, dp_resp_sat,
        output issue_ready, dp_valid, dp_op, dp_vsew, dp_vxrm, dp_elem_idx
    );

    modport slave (
        output issue_valid, issue_op, issue_vl, issue_vsew, issue_vxrm, issue_vm,
               mask_bit, dp_ready, dp_resp_valid, dp_resp_sat,
        input  issue_ready, dp_valid, dp_op, dp_vsew, dp_vxrm, dp_elem_idx
    );

endinterface

// File: rtl/fxp_outstanding_ctr.sv
// Up/down count of issued-but-unanswered datapath elements; decrements at zero are dropped.
module fxp_outstanding_ctr
    import fxp_seq_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic             dec_taken,
    output logic [CNT_W-1:0] count_next,
    output logic             full
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        dec_taken = dec && (count_q != '0);
        count_d   = count_q;
        unique case ({inc, dec_taken})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    assign count_next = count_d;
    assign full       = (count_q >= CNT_W'(MAX_OUTSTANDING));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

endmodule

// File: rtl/fixed_point_sequencer.sv
// Walks the elements of one fixed-point vector instruction through the datapath.
// Optional perf_elem_cnt/perf_stall_cnt outputs exist only with FXP_SEQ_PERF_EN defined.
module fixed_point_sequencer
    import fxp_seq_pkg::*;
#(
    parameter int ELEM_W          = 8,
    parameter int OP_W            = 6,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    fixed_point_sequencer_if.master bus,
    output logic                    busy,
    output logic                    done,
    output logic                    vxsat_set,
    output logic                    illegal
`ifdef FXP_SEQ_PERF_EN
    ,
    output logic [31:0]             perf_elem_cnt,
    output logic [31:0]             perf_stall_cnt
`endif
);

    state_e            state_q, state_d;
    logic [ELEM_W-1:0] idx_q, idx_d;
    logic [ELEM_W-1:0] vl_q, vl_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [2:0]        vsew_q, vsew_d;
    logic [1:0]        vxrm_q, vxrm_d;
    logic              vm_q, vm_d;
    logic              sat_acc_q, sat_acc_d;
    logic              illegal_q, illegal_d;

    logic             active, fire, dp_valid, issue_ready;
    logic             resp_taken, full;
    logic [CNT_W-1:0] cnt_next;

    fxp_outstanding_ctr #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc        (fire),
        .dec        (bus.dp_resp_valid),
        .dec_taken  (resp_taken),
        .count_next (cnt_next),
        .full       (full)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        vl_d        = vl_q;
        op_d        = op_q;
        vsew_d      = vsew_q;
        vxrm_d      = vxrm_q;
        vm_d        = vm_q;
        illegal_d   = illegal_q;
        sat_acc_d   = sat_acc_q | (resp_taken && bus.dp_resp_sat && (state_q != IDLE));
        issue_ready = 1'b0;
        active      = 1'b0;
        dp_valid    = 1'b0;
        fire        = 1'b0;
        done        = 1'b0;
        vxsat_set   = 1'b0;
        illegal     = 1'b0;

        unique case (state_q)
            IDLE: begin
                issue_ready = 1'b1;
                idx_d       = '0;
                if (bus.issue_valid) begin
                    op_d      = bus.issue_op;
                    vl_d      = bus.issue_vl;
                    vsew_d    = bus.issue_vsew;
                    vxrm_d    = bus.issue_vxrm;
                    vm_d      = bus.issue_vm;
                    sat_acc_d = 1'b0;
                    illegal_d = fxp_illegal(32'(bus.issue_op), 32'(bus.issue_vsew));
                    if (illegal_d || (bus.issue_vl == '0)) state_d = DONE;
                    else                                   state_d = ISSUE;
                end
            end
            ISSUE: begin
                active   = vm_q || bus.mask_bit;
                dp_valid = active && !full;
                fire     = dp_valid && bus.dp_ready;
                // Masked-off elements advance without touching the datapath.
                if (fire || !active) begin
                    if (idx_q == vl_q - ELEM_W'(1)) state_d = DRAIN;
                    else                            idx_d   = idx_q + ELEM_W'(1);
                end
            end
            DRAIN: begin
                if (cnt_next == '0) state_d = DONE;
            end
            DONE: begin
                done      = 1'b1;
                vxsat_set = sat_acc_q;
                illegal   = illegal_q;
                idx_d     = '0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            vl_q      <= '0;
            op_q      <= '0;
            vsew_q    <= '0;
            vxrm_q    <= '0;
            vm_q      <= 1'b0;
            sat_acc_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            vl_q      <= vl_d;
            op_q      <= op_d;
            vsew_q    <= vsew_d;
            vxrm_q    <= vxrm_d;
            vm_q      <= vm_d;
            sat_acc_q <= sat_acc_d;
            illegal_q <= illegal_d;
        end
    end

    assign busy            = (state_q != IDLE);
    assign bus.issue_ready = issue_ready;
    assign bus.dp_valid    = dp_valid;
    assign bus.dp_op       = op_q;
    assign bus.dp_vsew     = vsew_q;
    assign bus.dp_vxrm     = vxrm_q;
    assign bus.dp_elem_idx = idx_q;

`ifdef FXP_SEQ_PERF_EN
    logic [31:0] perf_elem_q, perf_elem_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_elem_d  = perf_elem_q;
        perf_stall_d = perf_stall_q;
        if (fire && (perf_elem_q != '1)) perf_elem_d = perf_elem_q + 32'd1;
        if (active && !fire && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_elem_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_elem_q  <= perf_elem_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_elem_cnt  = perf_elem_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule
